// File: rtl/pwm_multi.sv
// Multi-channel double-buffered PWM generator: one shared edge/center-aligned
// counter, per-channel pending/active duty levels swapped only at period boundaries.
module pwm_multi #(
    parameter int  WIDTH    = 8,
    parameter int  CHANNELS = 4,
    parameter bit  INVERT   = 1'b0,
    localparam int CH_BITS  = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                center,
    input  logic [WIDTH-1:0]    period,
    input  logic                wr_en,
    input  logic [CH_BITS-1:0]  wr_ch,
    input  logic [WIDTH-1:0]    wr_level,
    output logic [CHANNELS-1:0] out,
    output logic                sync
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [CH_BITS:0] CH_LIMIT = (CH_BITS + 1)'(CHANNELS);

    logic [WIDTH-1:0]    count_q, count_d;
    dir_t                dir_q, dir_d;
    logic [WIDTH-1:0]    period_q, period_d;
    logic                center_q, center_d;
    logic [WIDTH-1:0]    pending_q [CHANNELS];
    logic [WIDTH-1:0]    pending_d [CHANNELS];
    logic [WIDTH-1:0]    active_q  [CHANNELS];
    logic [WIDTH-1:0]    active_d  [CHANNELS];
    logic [CHANNELS-1:0] out_q, out_d;
    logic                sync_q, sync_d;
    logic                wrap_s;
    logic                load_s;
    logic                wr_ok_s;

    // Counter sequencing: wrap_s marks the edge on which count returns to 0.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        wrap_s  = 1'b0;
        if (!enable) begin
            count_d = {WIDTH{1'b0}};
            dir_d   = DIR_UP;
        end else if (!center_q) begin
            if (count_q >= period_q) begin
                wrap_s = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else begin
            case (dir_q)
                DIR_UP: begin
                    if (count_q >= period_q) begin
                        // P of 0 or 1 has no down leg: the period is just 0..P.
                        if (period_q <= WIDTH'(1)) begin
                            wrap_s = 1'b1;
                        end else begin
                            count_d = count_q - WIDTH'(1);
                            dir_d   = DIR_DOWN;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                DIR_DOWN: begin
                    if (count_q <= WIDTH'(1)) begin
                        wrap_s = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                default: begin
                    wrap_s = 1'b1;
                end
            endcase
        end
        if (wrap_s) begin
            count_d = {WIDTH{1'b0}};
            dir_d   = DIR_UP;
        end else begin
            count_d = count_d;
        end
    end

    assign load_s  = !enable || wrap_s;
    assign wr_ok_s = wr_en && ({1'b0, wr_ch} < CH_LIMIT);

    // Level buffers; a write landing on a load edge is forwarded via pending_d.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_ok_s && (wr_ch == CH_BITS'(c))) begin
                pending_d[c] = wr_level;
            end else begin
                pending_d[c] = pending_q[c];
            end
            if (load_s) begin
                active_d[c] = pending_d[c];
            end else begin
                active_d[c] = active_q[c];
            end
        end
        if (load_s) begin
            period_d = period;
            center_d = center;
        end else begin
            period_d = period_q;
            center_d = center_q;
        end
    end

    // Compare stage feeding the registered outputs.
    always_comb begin
        out_d  = {CHANNELS{INVERT}};
        sync_d = 1'b0;
        if (enable) begin
            for (int c = 0; c < CHANNELS; c++) begin
                out_d[c] = (count_q < active_q[c]) ^ INVERT;
            end
            sync_d = (count_q == {WIDTH{1'b0}});
        end else begin
            out_d  = {CHANNELS{INVERT}};
            sync_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= {WIDTH{1'b0}};
            dir_q    <= DIR_UP;
            period_q <= {WIDTH{1'b0}};
            center_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                pending_q[c] <= {WIDTH{1'b0}};
                active_q[c]  <= {WIDTH{1'b0}};
            end
            out_q    <= {CHANNELS{INVERT}};
            sync_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            dir_q    <= dir_d;
            period_q <= period_d;
            center_q <= center_d;
            for (int c = 0; c < CHANNELS; c++) begin
                pending_q[c] <= pending_d[c];
                active_q[c]  <= active_d[c];
            end
            out_q    <= out_d;
            sync_q   <= sync_d;
        end
    end

    assign out  = out_q;
    assign sync = sync_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a 4-channel plain instance and a 3-channel
// inverted instance share stimulus; a position-based model predicts each cycle.
module tb_pwm_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       center;
    logic [7:0] period;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_level;
    logic [3:0] out_a;
    logic       sync_a;
    logic [2:0] out_b;
    logic       sync_b;

    pwm_multi #(.WIDTH(8), .CHANNELS(4), .INVERT(1'b0)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .center(center), .period(period),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_level(wr_level), .out(out_a), .sync(sync_a)
    );

    pwm_multi #(.WIDTH(8), .CHANNELS(3), .INVERT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .center(center), .period(period),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_level(wr_level), .out(out_b), .sync(sync_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] oa;
        logic       sy;
        logic [2:0] ob;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: position within the period, levels as plain integers.
    int m_pos, m_p, m_ctr;
    int m_pend[4];
    int m_act[4];

    // Observation accumulators for the directed period-level checks.
    int       hi_a[4];
    int       n_sync, lo_b0, b_busy;
    logic [7:0] pat0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_p = 0; m_ctr = 0;
        for (int c = 0; c < 4; c++) begin
            m_pend[c] = 0;
            m_act[c]  = 0;
        end
    endtask

    function automatic int m_count();
        if (m_ctr == 0 || m_pos <= m_p) return m_pos;
        return 2 * m_p - m_pos;
    endfunction

    task automatic clear_obs();
        for (int c = 0; c < 4; c++) hi_a[c] = 0;
        n_sync = 0; lo_b0 = 0; b_busy = 0; pat0 = 8'h00;
    endtask

    task automatic tick();
        exp_t e;
        int   cnt, len;
        bit   load;
        cnt = m_count();
        if (enable) begin
            for (int c = 0; c < 4; c++) e.oa[c] = (cnt < m_act[c]);
            e.sy = (cnt == 0);
            e.ob = ~e.oa[2:0];
        end else begin
            e.oa = 4'b0000;
            e.sy = 1'b0;
            e.ob = 3'b111;
        end
        sb.push_back(e);
        if (wr_en) m_pend[wr_ch] = int'(wr_level);
        load = 1'b0;
        if (!enable) begin
            m_pos = 0;
            load  = 1'b1;
        end else begin
            len = (m_ctr != 0) ? ((m_p == 0) ? 1 : 2 * m_p) : m_p + 1;
            if (m_pos + 1 >= len) begin
                m_pos = 0;
                load  = 1'b1;
            end else begin
                m_pos++;
            end
        end
        if (load) begin
            for (int c = 0; c < 4; c++) m_act[c] = m_pend[c];
            m_p   = int'(period);
            m_ctr = int'(center);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("cycle_out_a", 32'(out_a), 32'(e.oa));
        check("cycle_sync_a", 32'(sync_a), 32'(e.sy));
        check("cycle_out_b", 32'(out_b), 32'(e.ob));
        check("cycle_sync_b", 32'(sync_b), 32'(e.sy));
        for (int c = 0; c < 4; c++) hi_a[c] += int'(out_a[c]);
        n_sync += int'(sync_a);
        if (!out_b[0]) lo_b0++;
        if (out_b != 3'b111) b_busy++;
        pat0 = {pat0[6:0], out_a[0]};
    endtask

    task automatic wr_tick(input logic [1:0] ch, input logic [7:0] lv);
        wr_en = 1'b1; wr_ch = ch; wr_level = lv;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; center = 1'b0; period = 8'd0;
        wr_en = 1'b0; wr_ch = 2'd0; wr_level = 8'd0;
        model_reset();
        clear_obs();
        #2;
        check("reset_out_a", 32'(out_a), 32'h0);
        check("reset_sync", 32'(sync_a), 32'h0);
        check("reset_out_b_idle", 32'(out_b), 32'h7);
        @(posedge clk); #1;
        reset = 1'b0;

        // Edge mode P=9 with L = 3, 0, 10, 9 (ch3 is out of range for dut_b).
        period = 8'd9;
        wr_tick(2'd0, 8'd3); wr_tick(2'd1, 8'd0); wr_tick(2'd2, 8'd10); wr_tick(2'd3, 8'd9);
        tick();
        check("disabled_b_idle", 32'(b_busy), 32'd0);
        enable = 1'b1;
        clear_obs();
        repeat (20) tick();
        check("edge_sync_count", 32'(n_sync), 32'd2);
        check("edge_hi_l3", 32'(hi_a[0]), 32'd6);
        check("edge_hi_l0", 32'(hi_a[1]), 32'd0);
        check("edge_hi_l10", 32'(hi_a[2]), 32'd20);
        check("edge_hi_l9", 32'(hi_a[3]), 32'd18);
        check("invert_lo_l3", 32'(lo_b0), 32'd6);

        // Mid-period write: current period keeps 3, next shows 7.
        clear_obs();
        repeat (4) tick();
        wr_tick(2'd0, 8'd7);
        repeat (5) tick();
        check("midwr_old_hi", 32'(hi_a[0]), 32'd3);
        check("midwr_sync", 32'(n_sync), 32'd1);
        clear_obs();
        repeat (10) tick();
        check("midwr_new_hi", 32'(hi_a[0]), 32'd7);

        // Write on the boundary cycle is forwarded into the next period.
        clear_obs();
        repeat (9) tick();
        wr_tick(2'd0, 8'd2);
        check("bndwr_old_hi", 32'(hi_a[0]), 32'd7);
        clear_obs();
        repeat (10) tick();
        check("bndwr_new_hi", 32'(hi_a[0]), 32'd2);

        // Period 9 -> 4 mid-period: finish at 10 cycles, then every 5.
        clear_obs();
        repeat (3) tick();
        period = 8'd4;
        repeat (7) tick();
        check("perchg_old_sync", 32'(n_sync), 32'd1);
        clear_obs();
        repeat (10) tick();
        check("perchg_new_sync", 32'(n_sync), 32'd2);
        check("perchg_new_hi", 32'(hi_a[0]), 32'd4);

        // Center mode P=4, L0=2 takes over at the next boundary.
        center = 1'b1;
        repeat (5) tick();
        clear_obs();
        repeat (8) tick();
        check("center_pattern", 32'(pat0), 32'hC1);
        check("center_sync1", 32'(n_sync), 32'd1);
        repeat (8) tick();
        check("center_sync2", 32'(n_sync), 32'd2);
        check("center_hi_l2", 32'(hi_a[0]), 32'd6);
        check("center_hi_lgtp", 32'(hi_a[3]), 32'd16);

        // Enable low: idle outputs, no sync.
        enable = 1'b0;
        clear_obs();
        repeat (3) tick();
        check("disable_sync", 32'(n_sync), 32'd0);
        check("disable_hi_a2", 32'(hi_a[2]), 32'd0);
        check("disable_b_idle", 32'(b_busy), 32'd0);

        // Asynchronous reset while sync and out_a[2] are high.
        enable = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("areset_out_a", 32'(out_a), 32'h0);
        check("areset_sync", 32'(sync_a), 32'h0);
        check("areset_out_b", 32'(out_b), 32'h7);
        model_reset();
        sb.delete();
        @(posedge clk); #1;
        check("reset_hold_out_a", 32'(out_a), 32'h0);
        reset  = 1'b0;
        enable = 1'b0;
        center = 1'b0;
        period = 8'd9;

        // wr_ch=3 is a real channel for dut_a but out of range for dut_b.
        wr_tick(2'd3, 8'd5);
        tick();
        enable = 1'b1;
        clear_obs();
        repeat (10) tick();
        check("post_reset_hi_a0", 32'(hi_a[0]), 32'd0);
        check("post_reset_hi_a3", 32'(hi_a[3]), 32'd5);
        check("oor_write_b_idle", 32'(b_busy), 32'd0);
        check("post_reset_sync", 32'(n_sync), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
